// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Widths that fix the write-buffer entry layout; the responder's width and
  // depth parameters default to these and must stay in agreement with them.
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DEPTH  = 1024;
  localparam int STRB_W      = DMEM_DATA_W / 8;
  localparam int IDX_W       = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]       index;
    logic [DMEM_DATA_W-1:0] data;
    logic [STRB_W-1:0]      strobe;
  } wb_entry_t;

  // Word index of a byte address. Byte-offset bits and everything above the
  // index are dropped, so out-of-range addresses alias onto the RAM.
  function automatic logic [IDX_W-1:0] word_index(input logic [DMEM_ADDR_W-1:0] addr);
    return IDX_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO with per-entry index compare and a fixed-latency drain engine.
// Latency: head entry commits WR_LATENCY cycles after reaching the head (+1 per blocked cycle).
// Backpressure: full is raised at WB_DEPTH entries; commit_block holds the final drain cycle.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   push, push_index/data/strobe  store to enqueue (caller guarantees !full)
//   rd_index, match               load index and "some valid entry holds it"
//   commit_block                  RAM port busy with a read this cycle
//   full, empty                   occupancy flags
//   commit, commit_index/data/strobe  RAM write of the head entry this cycle
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH   = 2,
  parameter int WR_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [IDX_W-1:0]       push_index,
  input  logic [DMEM_DATA_W-1:0] push_data,
  input  logic [STRB_W-1:0]      push_strobe,
  input  logic [IDX_W-1:0]       rd_index,
  input  logic                   commit_block,
  output logic                   full,
  output logic                   empty,
  output logic                   match,
  output logic                   commit,
  output logic [IDX_W-1:0]       commit_index,
  output logic [DMEM_DATA_W-1:0] commit_data,
  output logic [STRB_W-1:0]      commit_strobe
);

  localparam int CNT_W  = $clog2(WB_DEPTH + 1);
  localparam int SLOT_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int LAT_W  = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

  // Shift-register FIFO: ent[0] is always the head, valid entries are [0, count).
  wb_entry_t          ent [WB_DEPTH];
  logic [CNT_W-1:0]   count;
  logic [LAT_W-1:0]   age;
  logic               last_cycle;
  logic [SLOT_W-1:0]  wr_slot;

  assign full          = (count == CNT_W'(WB_DEPTH));
  assign empty         = (count == '0);
  assign last_cycle    = (age == LAT_W'(WR_LATENCY - 1));
  assign commit        = !empty && last_cycle && !commit_block;
  assign commit_index  = ent[0].index;
  assign commit_data   = ent[0].data;
  assign commit_strobe = ent[0].strobe;

  // A push that coincides with a pop lands one slot lower, behind the shift.
  assign wr_slot = SLOT_W'(count - (commit ? CNT_W'(1) : CNT_W'(0)));

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (i < int'(count) && ent[i].index == rd_index) begin
        match = 1'b1;
      end
    end
  end

  // Entry payload needs no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        ent[i] <= ent[i + 1];
      end
    end
    if (push) begin
      ent[wr_slot] <= '{index: push_index, data: push_data, strobe: push_strobe};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      age   <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(commit);
      // age counts cycles the current head has been held; a blocked final
      // cycle simply holds so the commit slips by one.
      if (empty || commit) begin
        age <= '0;
      end else if (!last_cycle) begin
        age <= age + LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory slave: word RAM behind a posted write buffer and a load FSM.
// Latency: loads return 1+RD_LATENCY cycles after request (more if a buffered store aliases).
// Backpressure: data_mem_hazard stalls the CPU for loads in flight and stores to a full buffer.
//
// Ports:
//   cpu_clk, cpu_rst                      clock, async active-high reset
//   cpu_data_mem_read/raddr               load request and byte address
//   data_mem_rdata                        load data, valid while the load completes
//   data_mem_hazard                       stall; requester holds inputs while high
//   cpu_data_mem_write/waddr/wdata/write_strobe  store request, lane-aligned data, byte enables
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH      = DMEM_DATA_W,
  parameter int DATA_ADDR_WIDTH = DMEM_ADDR_W,
  parameter int MEM_DEPTH       = DMEM_DEPTH,
  parameter int RD_LATENCY      = 1,
  parameter int WR_LATENCY      = 2,
  parameter int WB_DEPTH        = 2
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       cpu_data_mem_read,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
  output logic [DATA_WIDTH-1:0]      data_mem_rdata,
  output logic                       data_mem_hazard,
  input  logic                       cpu_data_mem_write,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
  input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]    cpu_data_mem_write_strobe
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

  dmem_state_e             state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   ram [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [IDX_W-1:0]        rd_index, wr_index;
  logic                    load_req, fsm_stall, full_stall, push, ram_rd;
  logic                    wb_full, wb_empty, wb_match, wb_commit;
  logic [IDX_W-1:0]        wb_commit_index;
  logic [DATA_WIDTH-1:0]   wb_commit_data;
  logic [STRB_W-1:0]       wb_commit_strobe;

  assign rd_index = word_index(cpu_data_mem_raddr);
  assign wr_index = word_index(cpu_data_mem_waddr);

  // A simultaneous store wins; the load is ignored and raises no stall.
  assign load_req   = cpu_data_mem_read && !cpu_data_mem_write;
  assign fsm_stall  = (state == IDLE && load_req) || state == DRAIN || state == RD_WAIT;
  // A pop in the same cycle deliberately does not relieve a full buffer.
  assign full_stall = cpu_data_mem_write && wb_full;
  // Gated by reset so the stall drops immediately even if a load is held.
  assign data_mem_hazard = !cpu_rst && (fsm_stall || full_stall);
  assign push   = cpu_data_mem_write && !data_mem_hazard;
  assign ram_rd = (state == RD_WAIT) && (cnt == '0);
  assign data_mem_rdata = rdata_q;

  dmem_write_buffer #(
    .WB_DEPTH  (WB_DEPTH),
    .WR_LATENCY(WR_LATENCY)
  ) u_wbuf (
    .clk          (cpu_clk),
    .rst          (cpu_rst),
    .push         (push),
    .push_index   (wr_index),
    .push_data    (cpu_data_mem_wdata),
    .push_strobe  (cpu_data_mem_write_strobe),
    .rd_index     (rd_index),
    .commit_block (ram_rd),
    .full         (wb_full),
    .empty        (wb_empty),
    .match        (wb_match),
    .commit       (wb_commit),
    .commit_index (wb_commit_index),
    .commit_data  (wb_commit_data),
    .commit_strobe(wb_commit_strobe)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load_req) begin
          // A buffered store to the same word must reach RAM before the read.
          if (wb_match) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = RD_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      DRAIN: begin
        if (wb_empty) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_nxt = RD_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ram_rd) begin
        rdata_q <= ram[rd_index];
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge cpu_clk) begin
    if (wb_commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wb_commit_strobe[b]) begin
          ram[wb_commit_index][b*8 +: 8] <= wb_commit_data[b*8 +: 8];
        end
      end
    end
  end

endmodule
